// File: rtl/riscv_core_lsu_ctrl.sv
// Load/store sequencer between execute and the data-memory req/gnt/rvalid port. Optional macro: RISCV_LSU_MISALIGN_TRAP_EN.
// Latency (accept edge to done sampled): store 2, load 3; +1 per gnt/rvalid wait cycle; misalign trap 1.
// Backpressure: o_lsu_ready only in IDLE, so one transaction is outstanding; o_dmem_req is held until i_dmem_gnt.
module riscv_core_lsu_ctrl #(
  parameter int XLEN = 64
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_lsu_valid,
  output logic            o_lsu_ready,
  input  logic            i_lsu_we,
  input  logic [1:0]      i_lsu_size,
  input  logic            i_lsu_su_extend,
  input  logic [XLEN-1:0] i_lsu_addr,
  input  logic [XLEN-1:0] i_lsu_wdata,
  output logic            o_lsu_done,
  output logic [XLEN-1:0] o_lsu_rdata,
  output logic            o_lsu_misalign,
  output logic            o_dmem_req,
  input  logic            i_dmem_gnt,
  output logic            o_dmem_we,
  output logic [XLEN-1:0] o_dmem_addr,
  output logic [7:0]      o_dmem_be,
  output logic [XLEN-1:0] o_dmem_wdata,
  input  logic            i_dmem_rvalid,
  input  logic [XLEN-1:0] i_dmem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              su_q, su_d;
  logic [2:0]        off_q, off_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic              req_q, req_d;
  logic              dwe_q, dwe_d;
  logic [XLEN-1:0]   daddr_q, daddr_d;
  logic [7:0]        be_q, be_d;
  logic [XLEN-1:0]   dwdata_q, dwdata_d;
  logic [XLEN-1:0]   rd_shifted;
  logic [7:0]        be_base;
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
  logic              mis_q, mis_d;
  logic              req_mis;
`endif

  // Next-state, latched operands and registered outputs for the LSU FSM
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    size_d   = size_q;
    su_d     = su_q;
    off_d    = off_q;
    rdata_d  = rdata_q;
    dwe_d    = dwe_q;
    daddr_d  = daddr_q;
    be_d     = be_q;
    dwdata_d = dwdata_q;
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
    mis_d    = mis_q;
    req_mis  = ((i_lsu_size == 2'b01) && i_lsu_addr[0]) ||
               ((i_lsu_size == 2'b10) && (i_lsu_addr[1:0] != 2'b00)) ||
               ((i_lsu_size == 2'b11) && (i_lsu_addr[2:0] != 3'b000));
`endif
    // Lane mask before shifting to the byte offset; bits past lane 7 fall off.
    case (i_lsu_size)
      2'b00:   be_base = 8'h01;
      2'b01:   be_base = 8'h03;
      2'b10:   be_base = 8'h0F;
      default: be_base = 8'hFF;
    endcase
    rd_shifted = i_dmem_rdata >> {off_q, 3'b000};

    case (state_q)
      IDLE: begin
        if (i_lsu_valid) begin
          we_d     = i_lsu_we;
          size_d   = i_lsu_size;
          su_d     = i_lsu_su_extend;
          off_d    = i_lsu_addr[2:0];
          rdata_d  = '0;
          dwe_d    = i_lsu_we;
          daddr_d  = {i_lsu_addr[XLEN-1:3], 3'b000};
          be_d     = be_base << i_lsu_addr[2:0];
          dwdata_d = i_lsu_wdata << {i_lsu_addr[2:0], 3'b000};
          state_d  = REQ;
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
          mis_d    = req_mis;
          if (req_mis) begin
            state_d = RESP;
          end
`endif
        end
      end
      REQ: begin
        if (i_dmem_gnt) begin
          state_d = we_q ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (i_dmem_rvalid) begin
          case (size_q)
            2'b00:   rdata_d = su_q ? {{(XLEN-8){1'b0}}, rd_shifted[7:0]}
                                    : {{(XLEN-8){rd_shifted[7]}}, rd_shifted[7:0]};
            2'b01:   rdata_d = su_q ? {{(XLEN-16){1'b0}}, rd_shifted[15:0]}
                                    : {{(XLEN-16){rd_shifted[15]}}, rd_shifted[15:0]};
            2'b10:   rdata_d = su_q ? {{(XLEN-32){1'b0}}, rd_shifted[31:0]}
                                    : {{(XLEN-32){rd_shifted[31]}}, rd_shifted[31:0]};
            default: rdata_d = rd_shifted;
          endcase
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
    done_d  = (state_d == RESP);
    req_d   = (state_d == REQ);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      size_q   <= 2'b00;
      su_q     <= 1'b0;
      off_q    <= 3'b000;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      rdata_q  <= '0;
      req_q    <= 1'b0;
      dwe_q    <= 1'b0;
      daddr_q  <= '0;
      be_q     <= 8'h00;
      dwdata_q <= '0;
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
      mis_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      size_q   <= size_d;
      su_q     <= su_d;
      off_q    <= off_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      rdata_q  <= rdata_d;
      req_q    <= req_d;
      dwe_q    <= dwe_d;
      daddr_q  <= daddr_d;
      be_q     <= be_d;
      dwdata_q <= dwdata_d;
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
      mis_q    <= mis_d;
`endif
    end
  end

  assign o_lsu_ready  = ready_q;
  assign o_lsu_done   = done_q;
  assign o_lsu_rdata  = rdata_q;
  // Request is withdrawn in the reset cycle itself, not one edge later.
  assign o_dmem_req   = req_q & ~i_rst;
  assign o_dmem_we    = dwe_q;
  assign o_dmem_addr  = daddr_q;
  assign o_dmem_be    = be_q;
  assign o_dmem_wdata = dwdata_q;
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
  assign o_lsu_misalign = mis_q;
`else
  assign o_lsu_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_riscv_core_lsu_ctrl.sv
// Directed bench for riscv_core_lsu_ctrl: vector table plus reset and held-request sequences.
// Latency is counted from the accept edge to the edge that samples o_lsu_done.
// Memory side responds with per-vector gnt/rvalid delays.
module tb_riscv_core_lsu_ctrl;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_lsu_valid;
  logic        o_lsu_ready;
  logic        i_lsu_we;
  logic [1:0]  i_lsu_size;
  logic        i_lsu_su_extend;
  logic [63:0] i_lsu_addr;
  logic [63:0] i_lsu_wdata;
  logic        o_lsu_done;
  logic [63:0] o_lsu_rdata;
  logic        o_lsu_misalign;
  logic        o_dmem_req;
  logic        i_dmem_gnt;
  logic        o_dmem_we;
  logic [63:0] o_dmem_addr;
  logic [7:0]  o_dmem_be;
  logic [63:0] o_dmem_wdata;
  logic        i_dmem_rvalid;
  logic [63:0] i_dmem_rdata;

  int passed = 0;
  int total  = 0;

  riscv_core_lsu_ctrl #(.XLEN(64)) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_lsu_valid(i_lsu_valid), .o_lsu_ready(o_lsu_ready),
    .i_lsu_we(i_lsu_we), .i_lsu_size(i_lsu_size), .i_lsu_su_extend(i_lsu_su_extend),
    .i_lsu_addr(i_lsu_addr), .i_lsu_wdata(i_lsu_wdata),
    .o_lsu_done(o_lsu_done), .o_lsu_rdata(o_lsu_rdata), .o_lsu_misalign(o_lsu_misalign),
    .o_dmem_req(o_dmem_req), .i_dmem_gnt(i_dmem_gnt), .o_dmem_we(o_dmem_we),
    .o_dmem_addr(o_dmem_addr), .o_dmem_be(o_dmem_be), .o_dmem_wdata(o_dmem_wdata),
    .i_dmem_rvalid(i_dmem_rvalid), .i_dmem_rdata(i_dmem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic        su;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    int          gdly;
    int          rdly;
    logic [7:0]  be;
    logic [63:0] daddr;
    logic [63:0] dwdata;
    logic [63:0] exp_rdata;
    logic        mis;
    int          lat;
    int          reqc;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    int cyc, gcnt, rcnt, reqc, w;
    bit granted;
    cyc = 0; gcnt = 0; rcnt = 0; reqc = 0; w = 0; granted = 0;
    while (!o_lsu_ready && w < 20) begin tick(); w++; end
    check({v.name, " ready"}, o_lsu_ready, 1'b1);
    i_lsu_valid = 1'b1; i_lsu_we = v.we; i_lsu_size = v.size; i_lsu_su_extend = v.su;
    i_lsu_addr = v.addr; i_lsu_wdata = v.wdata; i_dmem_rdata = v.rdata;
    tick();
    i_lsu_valid = 1'b0;
    while (!o_lsu_done && cyc < 60) begin
      i_dmem_gnt = 1'b0;
      i_dmem_rvalid = 1'b0;
      if (o_dmem_req) begin
        check({v.name, " be"}, o_dmem_be, v.be);
        check({v.name, " daddr"}, o_dmem_addr, v.daddr);
        check({v.name, " dwdata"}, o_dmem_wdata, v.dwdata);
        check({v.name, " dwe"}, o_dmem_we, v.we);
        reqc++;
        if (gcnt == v.gdly) begin i_dmem_gnt = 1'b1; granted = 1; end
        gcnt++;
      end else if (granted && !v.we) begin
        if (rcnt == v.rdly) i_dmem_rvalid = 1'b1;
        rcnt++;
      end
      tick();
      cyc++;
    end
    i_dmem_gnt = 1'b0;
    i_dmem_rvalid = 1'b0;
    check({v.name, " done"}, o_lsu_done, 1'b1);
    check({v.name, " latency"}, cyc + 1, v.lat);
    check({v.name, " req_cycles"}, reqc, v.reqc);
    check({v.name, " rdata"}, o_lsu_rdata, v.exp_rdata);
    check({v.name, " misalign"}, o_lsu_misalign, v.mis);
    check({v.name, " ready_in_done"}, o_lsu_ready, 1'b0);
    tick();
    check({v.name, " done_pulse"}, o_lsu_done, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, dn, last_done, bad;
    //          name        we  sz    su   addr        wdata                  rdata                  gd rd be     daddr       dwdata                 exp_rdata              mis lat reqc
    vecs[0] = '{"lb_sign",  0, 2'b00, 0, 64'h1003, 64'h0,                 64'h00000000_80000000, 0, 0, 8'h08, 64'h1000, 64'h0,                 64'hFFFFFFFF_FFFFFF80, 0, 3, 1};
    vecs[1] = '{"lw_zero",  0, 2'b10, 1, 64'h2004, 64'h0,                 64'h87654321_00000000, 0, 0, 8'hF0, 64'h2000, 64'h0,                 64'h00000000_87654321, 0, 3, 1};
    vecs[2] = '{"sh_gdly",  1, 2'b01, 0, 64'h3002, 64'hABCD,              64'h0,                 2, 0, 8'h0C, 64'h3000, 64'h00000000_ABCD0000, 64'h0,                 0, 4, 3};
    vecs[3] = '{"ld_rdly",  0, 2'b11, 0, 64'h5000, 64'h0,                 64'hDEADBEEF_CAFEF00D, 0, 3, 8'hFF, 64'h5000, 64'h0,                 64'hDEADBEEF_CAFEF00D, 0, 6, 1};
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
    vecs[4] = '{"lw_mis",   0, 2'b10, 0, 64'h4006, 64'h0,                 64'h11223344_55667788, 0, 0, 8'hC0, 64'h4000, 64'h0,                 64'h0,                 1, 1, 0};
`else
    vecs[4] = '{"lw_mis",   0, 2'b10, 0, 64'h4006, 64'h0,                 64'h11223344_55667788, 0, 0, 8'hC0, 64'h4000, 64'h0,                 64'h00000000_00001122, 0, 3, 1};
`endif
    vecs[5] = '{"lh_sign",  0, 2'b01, 0, 64'h6006, 64'h0,                 64'hF00D0000_00000000, 1, 1, 8'hC0, 64'h6000, 64'h0,                 64'hFFFFFFFF_FFFFF00D, 0, 5, 2};
    vecs[6] = '{"sb_top",   1, 2'b00, 0, 64'h7007, 64'h125A,              64'h0,                 0, 0, 8'h80, 64'h7000, 64'h5A000000_00000000, 64'h0,                 0, 2, 1};
    vecs[7] = '{"sd",       1, 2'b11, 0, 64'h8000, 64'h01234567_89ABCDEF, 64'h0,                 0, 0, 8'hFF, 64'h8000, 64'h01234567_89ABCDEF, 64'h0,                 0, 2, 1};
    vecs[8] = '{"lw_sign",  0, 2'b10, 0, 64'h9000, 64'h0,                 64'h00000000_80000001, 0, 0, 8'h0F, 64'h9000, 64'h0,                 64'hFFFFFFFF_80000001, 0, 3, 1};
    vecs[9] = '{"lb_zero",  0, 2'b00, 1, 64'hA005, 64'h0,                 64'h00009900_00000000, 0, 0, 8'h20, 64'hA000, 64'h0,                 64'h00000000_00000099, 0, 3, 1};

    i_rst = 1'b1; i_lsu_valid = 1'b0; i_lsu_we = 1'b0; i_lsu_size = 2'b00;
    i_lsu_su_extend = 1'b0; i_lsu_addr = '0; i_lsu_wdata = '0;
    i_dmem_gnt = 1'b0; i_dmem_rvalid = 1'b0; i_dmem_rdata = '0;
    repeat (3) tick();
    i_rst = 1'b0;
    check("rst ready", o_lsu_ready, 1'b1);
    check("rst done", o_lsu_done, 1'b0);
    check("rst req", o_dmem_req, 1'b0);
    check("rst be", o_dmem_be, 8'h00);
    check("rst rdata", o_lsu_rdata, 64'h0);

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Reset while a load waits for rvalid.
    i_lsu_valid = 1'b1; i_lsu_we = 1'b0; i_lsu_size = 2'b11; i_lsu_su_extend = 1'b0;
    i_lsu_addr = 64'hB000; i_lsu_wdata = 64'h0;
    tick();
    i_lsu_valid = 1'b0;
    check("wrst req", o_dmem_req, 1'b1);
    i_dmem_gnt = 1'b1;
    tick();
    i_dmem_gnt = 1'b0;
    check("wrst in_wait", o_dmem_req | o_lsu_done | o_lsu_ready, 1'b0);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    check("wrst ready", o_lsu_ready, 1'b1);
    check("wrst done", o_lsu_done, 1'b0);
    check("wrst rdata", o_lsu_rdata, 64'h0);
    check("wrst misalign", o_lsu_misalign, 1'b0);
    check("wrst req", o_dmem_req, 1'b0);
    check("wrst we", o_dmem_we, 1'b0);
    check("wrst be", o_dmem_be, 8'h00);
    check("wrst addr", o_dmem_addr, 64'h0);
    check("wrst wdata", o_dmem_wdata, 64'h0);

    // Reset while requesting: req must drop in the same cycle.
    i_lsu_valid = 1'b1; i_lsu_we = 1'b1; i_lsu_size = 2'b11; i_lsu_addr = 64'hC000;
    i_lsu_wdata = 64'h55;
    tick();
    i_lsu_valid = 1'b0;
    check("rrst req_before", o_dmem_req, 1'b1);
    i_rst = 1'b1;
    #1;
    check("rrst req_drop", o_dmem_req, 1'b0);
    tick();
    i_rst = 1'b0;
    check("rrst ready", o_lsu_ready, 1'b1);
    check("rrst be", o_dmem_be, 8'h00);

    // Requester holds valid through consecutive stores with immediate gnt.
    i_lsu_valid = 1'b1; i_lsu_we = 1'b1; i_lsu_size = 2'b10; i_lsu_addr = 64'hD000;
    i_lsu_wdata = 64'h1111;
    acc = 0; dn = 0; last_done = -10; bad = 0;
    for (int i = 0; i < 9; i++) begin
      if (o_lsu_ready && o_lsu_done) bad++;
      if (o_lsu_ready && i_lsu_valid) begin
        acc++;
        if (acc > 1) check("hold accept_after_done", i, last_done + 1);
      end
      if (o_lsu_done) begin dn++; last_done = i; end
      i_dmem_gnt = o_dmem_req;
      tick();
    end
    i_lsu_valid = 1'b0;
    i_dmem_gnt = 1'b0;
    check("hold accepts", acc, 3);
    check("hold dones", dn, 3);
    check("hold ready_and_done", bad, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
